// File: rtl/dac_spi_frame_rx.sv
// SPI responder for the slow-DAC link: oversamples SYNC/SCLK/MOSI, decodes
// {cmd, addr, data} frames and models the DAC's per-channel input/output registers.
module dac_spi_frame_rx #(
  parameter int unsigned          NCH      = 8,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [DATA_W-1:0]    INIT_VAL = 16'h8000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_sync,
  input  logic                    spi_sclk,
  input  logic                    spi_mosi,
  output logic [NCH*DATA_W-1:0]   dac_val,
  output logic                    upd_stb,
  output logic [NCH-1:0]          upd_mask,
  output logic [DATA_W+7:0]       last_frame,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              err_cnt,
  output logic                    busy
);

  localparam int unsigned FW = DATA_W + 8;
  localparam int unsigned CW = $clog2(FW + 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT, S_ERROR} state_t;

  state_t            state_q, state_d;
  logic              sync_m_q, sync_s_q, sync_q;
  logic              sclk_m_q, sclk_s_q, sclk_q;
  logic              mosi_m_q, mosi_s_q;
  logic [FW-1:0]     sreg_q, sreg_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] in_q  [NCH];
  logic [DATA_W-1:0] in_d  [NCH];
  logic [DATA_W-1:0] out_q [NCH];
  logic [DATA_W-1:0] out_d [NCH];
  logic              upd_stb_q, upd_stb_d;
  logic [NCH-1:0]    upd_mask_q, upd_mask_d;
  logic [FW-1:0]     last_frame_q, last_frame_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;

  logic              sync_fall, sync_rise, sclk_fall;
  logic [3:0]        cmd, addr;
  logic [DATA_W-1:0] data;
  logic [NCH-1:0]    sel;

  assign sync_fall = sync_q & ~sync_s_q;
  assign sync_rise = ~sync_q & sync_s_q;
  assign sclk_fall = sclk_q & ~sclk_s_q;

  assign cmd  = sreg_q[FW-1 -: 4];
  assign addr = sreg_q[FW-5 -: 4];
  assign data = sreg_q[DATA_W-1:0];

  always_comb begin
    sel = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      sel[n] = (addr == 4'hF) || (32'(addr) == n);
    end
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bitcnt_d     = bitcnt_q;
    in_d         = in_q;
    out_d        = out_q;
    upd_stb_d    = 1'b0;
    upd_mask_d   = '0;
    last_frame_d = last_frame_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (sync_fall) begin
          state_d  = S_SHIFT;
          busy_d   = 1'b1;
          bitcnt_d = '0;
          // An SCLK fall coincident with the SYNC fall is the frame's first bit.
          if (sclk_fall) begin
            sreg_d   = {sreg_q[FW-2:0], mosi_s_q};
            bitcnt_d = CW'(1);
          end
        end
      end
      S_SHIFT: begin
        if (sync_rise) begin
          state_d = (32'(bitcnt_q) == FW) ? S_COMMIT : S_ERROR;
        end else if (sclk_fall) begin
          sreg_d = {sreg_q[FW-2:0], mosi_s_q};
          if (32'(bitcnt_q) < FW + 1) bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      S_COMMIT: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        last_frame_d = sreg_q;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        case (cmd)
          4'h0: begin
            for (int unsigned n = 0; n < NCH; n++) if (sel[n]) in_d[n] = data;
          end
          4'h1: begin
            for (int unsigned n = 0; n < NCH; n++) if (sel[n]) out_d[n] = in_q[n];
            upd_stb_d  = |sel;
            upd_mask_d = sel;
          end
          4'h2: begin
            // Load then update-all: every output takes the freshly written input bank.
            if (|sel) begin
              for (int unsigned n = 0; n < NCH; n++) begin
                in_d[n]  = sel[n] ? data : in_q[n];
                out_d[n] = in_d[n];
              end
              upd_stb_d  = 1'b1;
              upd_mask_d = '1;
            end
          end
          4'h3: begin
            for (int unsigned n = 0; n < NCH; n++) begin
              if (sel[n]) begin
                in_d[n]  = data;
                out_d[n] = data;
              end
            end
            upd_stb_d  = |sel;
            upd_mask_d = sel;
          end
          default: ;
        endcase
      end
      S_ERROR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // Synchronisers clear low so a SYNC held low through reset is not seen as a fall.
      sync_m_q     <= 1'b0;
      sync_s_q     <= 1'b0;
      sync_q       <= 1'b0;
      sclk_m_q     <= 1'b0;
      sclk_s_q     <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_m_q     <= 1'b0;
      mosi_s_q     <= 1'b0;
      sreg_q       <= '0;
      bitcnt_q     <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        in_q[n]  <= INIT_VAL;
        out_q[n] <= INIT_VAL;
      end
      upd_stb_q    <= 1'b0;
      upd_mask_q   <= '0;
      last_frame_q <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_m_q     <= spi_sync;
      sync_s_q     <= sync_m_q;
      sync_q       <= sync_s_q;
      sclk_m_q     <= spi_sclk;
      sclk_s_q     <= sclk_m_q;
      sclk_q       <= sclk_s_q;
      mosi_m_q     <= spi_mosi;
      mosi_s_q     <= mosi_m_q;
      sreg_q       <= sreg_d;
      bitcnt_q     <= bitcnt_d;
      in_q         <= in_d;
      out_q        <= out_d;
      upd_stb_q    <= upd_stb_d;
      upd_mask_q   <= upd_mask_d;
      last_frame_q <= last_frame_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    dac_val = '0;
    for (int unsigned n = 0; n < NCH; n++) dac_val[n*DATA_W +: DATA_W] = out_q[n];
  end

  assign upd_stb    = upd_stb_q;
  assign upd_mask   = upd_mask_q;
  assign last_frame = last_frame_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// Directed bench for dac_spi_frame_rx: drives SPI frames at 1/6 of clk and
// checks register model, strobes and counters against hand-computed values.
module tb_dac_spi_frame_rx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_sync = 1'b1;
  logic         spi_sclk = 1'b0;
  logic         spi_mosi = 1'b0;
  logic [127:0] dac_val;
  logic         upd_stb;
  logic [7:0]   upd_mask;
  logic [23:0]  last_frame;
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
  logic         busy;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  int unsigned  stb_cnt = 0;
  logic [7:0]   mask_last = '0;
  int unsigned  stb_base;

  always #5 clk = ~clk;

  dac_spi_frame_rx #(.NCH(8), .DATA_W(16), .INIT_VAL(16'h8000)) dut (
    .clk(clk), .rst(rst), .spi_sync(spi_sync), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .dac_val(dac_val), .upd_stb(upd_stb), .upd_mask(upd_mask), .last_frame(last_frame),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  always @(negedge clk) begin
    if (upd_stb) begin
      stb_cnt   <= stb_cnt + 1;
      mask_last <= upd_mask;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int n);
    return dac_val[n*16 +: 16];
  endfunction

  task automatic shift_bits(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = w[i];
      wait_clk(2);
      spi_sclk = 1'b1;
      wait_clk(2);
      spi_sclk = 1'b0;
      wait_clk(2);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits);
    spi_sync = 1'b0;
    wait_clk(4);
    shift_bits(w, nbits);
    wait_clk(2);
    spi_sync = 1'b1;
    wait_clk(12);
    @(negedge clk);
  endtask

  initial begin
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    @(negedge clk);
    for (int n = 0; n < 8; n++) check($sformatf("reset_lane%0d", n), 32'(lane(n)), 32'h8000);
    check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    check("reset_err_cnt", 32'(err_cnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_upd_stb", 32'(upd_stb), 32'h0);
    check("reset_last_frame", 32'(last_frame), 32'h0);

    // write input+output ch2
    stb_base = stb_cnt;
    send_frame(32'h321234, 24);
    check("f1_ch2", 32'(lane(2)), 32'h1234);
    check("f1_ch1", 32'(lane(1)), 32'h8000);
    check("f1_mask", 32'(mask_last), 32'h04);
    check("f1_stb_cnt", stb_cnt - stb_base, 1);
    check("f1_frame_cnt", 32'(frame_cnt), 1);
    check("f1_last_frame", 32'(last_frame), 32'h321234);

    // input-only write then update
    stb_base = stb_cnt;
    send_frame(32'h05ABCD, 24);
    check("f2_ch5_unchanged", 32'(lane(5)), 32'h8000);
    check("f2_no_stb", stb_cnt - stb_base, 0);
    check("f2_frame_cnt", 32'(frame_cnt), 2);
    send_frame(32'h150000, 24);
    check("f3_ch5", 32'(lane(5)), 32'hABCD);
    check("f3_mask", 32'(mask_last), 32'h20);
    check("f3_stb_cnt", stb_cnt - stb_base, 1);

    // broadcast
    send_frame(32'h3F0F0F, 24);
    for (int n = 0; n < 8; n++) check($sformatf("f4_lane%0d", n), 32'(lane(n)), 32'h0F0F);
    check("f4_mask", 32'(mask_last), 32'hFF);
    check("f4_frame_cnt", 32'(frame_cnt), 4);

    // input load on ch2, then load ch1 and update all
    send_frame(32'h021111, 24);
    check("f5_ch2_unchanged", 32'(lane(2)), 32'h0F0F);
    stb_base = stb_cnt;
    send_frame(32'h212222, 24);
    check("f6_ch0", 32'(lane(0)), 32'h0F0F);
    check("f6_ch1", 32'(lane(1)), 32'h2222);
    check("f6_ch2", 32'(lane(2)), 32'h1111);
    check("f6_mask", 32'(mask_last), 32'hFF);
    check("f6_stb_cnt", stb_cnt - stb_base, 1);
    check("f6_frame_cnt", 32'(frame_cnt), 6);

    // short and overlong frames
    stb_base = stb_cnt;
    send_frame(32'h3F5555, 23);
    check("short_err_cnt", 32'(err_cnt), 1);
    send_frame(32'h0_3F5555, 26);
    check("long_err_cnt", 32'(err_cnt), 2);
    check("err_frame_cnt", 32'(frame_cnt), 6);
    check("err_ch1", 32'(lane(1)), 32'h2222);
    check("err_ch7", 32'(lane(7)), 32'h0F0F);
    check("err_no_stb", stb_cnt - stb_base, 0);
    check("err_last_frame", 32'(last_frame), 32'h212222);

    // reset mid-frame
    spi_sync = 1'b0;
    wait_clk(4);
    shift_bits(32'h3F0000, 12);
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    spi_sync = 1'b1;
    wait_clk(8);
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_frame_cnt", 32'(frame_cnt), 0);
    check("rst_mid_err_cnt", 32'(err_cnt), 0);
    send_frame(32'h307FFF, 24);
    check("f7_ch0", 32'(lane(0)), 32'h7FFF);
    check("f7_ch1", 32'(lane(1)), 32'h8000);
    check("f7_frame_cnt", 32'(frame_cnt), 1);
    check("f7_err_cnt", 32'(err_cnt), 0);
    check("f7_mask", 32'(mask_last), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
